mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multicycle-processor successor to the single-cycle control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- Supports R-type, LW, SW, ADDI, ORI, BEQ, BNE, J and JAL.
- Adds a variable-latency memory handshake, an optional memory timeout, and illegal-opcode trapping.
- Sits beside the multicycle datapath; drives all mux selects and write enables.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_ready before bus error; 0 disables the timeout.
- TRAP_HALT, 1, 1 = illegal opcode halts in TRAP; 0 = pulse illegal_op and refetch.
- HAS_JAL, 1, 0 = opcode 000011 is treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- mem_ready  in  1  memory completes the current read/write this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load (datapath ANDs with zero^invertzero)
- invertzero  out  1  1 for BNE
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- memtoreg  out  1  writeback from MDR
- regdst  out  2  00 rt, 01 rd, 10 r31
- regwrite  out  1  register-file write
- link  out  1  writeback data = PC (JAL)
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- zeroext  out  1  zero-extend immediate (ORI)
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse on unknown opcode/funct
- bus_error  out  1  sticky; set on memory timeout
- instr_done  out  1  one-cycle pulse in the last state of each instruction

Behaviour:
- Reset: async assert of rst_n forces state FETCH, timeout counter 0, bus_error 0. All other outputs are Moore-decoded from state; in FETCH only memread=1, alusrcb=01 and alucontrol=010 are nonzero. Reset mid-instruction abandons it; the first post-reset cycle is FETCH.
- Outputs not listed for a state are 0.
- FETCH: memread, iord=0, alusrca=0, alusrcb=01, add. On mem_ready: irwrite=1 and pcwrite=1 in the same cycle, then go to DECODE. Otherwise hold.
- DECODE: alusrca=0, alusrcb=11, add (branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 or 001101 -> IMMEX
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL (if HAS_JAL)
  - any other op -> TRAP
- MEMADR: alusrca=1, alusrcb=10, add. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1, memread. On mem_ready -> MEMWB.
- MEMWB: memtoreg=1, regdst=00, regwrite, instr_done. -> FETCH.
- MEMWR: iord=1, memwrite. On mem_ready: instr_done, -> FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other funct -> TRAP
  - valid funct -> ALUWB.
- ALUWB: regdst=01, regwrite, instr_done. -> FETCH.
- IMMEX: alusrca=1, alusrcb=10. ADDI: add, zeroext=0. ORI: or, zeroext=1. -> IMMWB.
- IMMWB: regdst=00, regwrite, zeroext held from the registered opcode class, instr_done. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01, invertzero=(op==000101), instr_done. -> FETCH.
- JUMP: pcsrc=10, pcwrite, instr_done. -> FETCH.
- JAL: pcsrc=10, pcwrite, regdst=10, link, regwrite, instr_done. -> FETCH. The PC already holds PC+4.
- TRAP: illegal_op pulses on the entry cycle only. TRAP_HALT=1: stay in TRAP until reset. TRAP_HALT=0: -> FETCH the next cycle.
- Timeout (MEM_TIMEOUT>0):
  - Counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Counter clears on mem_ready or state exit.
  - When count==MEM_TIMEOUT-1 with mem_ready=0: set bus_error and go to ERR.
  - ERR: all enables 0; held until reset.
  - mem_ready in the same cycle as the limit wins (no error).
- Op/funct are sampled only in DECODE/EXEC. IR is stable afterwards, so no internal opcode register is needed except the opcode class used by IMMWB/BRANCH.
- CPI: LW 5, SW 4, R/ADDI/ORI 4, BEQ/BNE/J/JAL 3, each plus memory wait cycles.

Decomposition:
- Package mips_mc_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, TRAP, ERR
  - opcode and funct localparams
  - alucontrol codes
  - alusrcb/pcsrc/regdst encodings
- Sub-module mc_funct_dec: combinational funct -> {alucontrol, valid}.

Test Plan:
- Reset with mem_ready=1, then R-type add (op 000000, funct 100000) -> states FETCH, DECODE, EXEC, ALUWB; alucontrol=010 in EXEC; regwrite=1, regdst=01 in ALUWB; instr_done once.
- LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 3 extra cycles with iord=1, memread=1; then MEMWB with memtoreg=1, regwrite=1; total 8 cycles.
- BNE (op 000101) -> BRANCH with branch=1, invertzero=1, pcsrc=01, alucontrol=110; next FETCH.
- JAL with HAS_JAL=1 -> regdst=10, link=1, pcwrite=1, pcsrc=10. Repeat with HAS_JAL=0 -> TRAP and illegal_op pulse.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error rises on the 4th cycle, ERR held. Assert rst_n=0 mid-ERR -> FETCH, bus_error=0.
- Unknown funct 111111 with TRAP_HALT=0 -> illegal_op one cycle, next state FETCH, no regwrite.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
        IMMEX, IMMWB, BRANCH, JUMP, JAL, TRAP, ERR
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

    // Datapath control bundle decoded from the current state.
    typedef struct packed {
        logic             pcwrite;
        logic             branch;
        logic             invertzero;
        logic             iord;
        logic             memread;
        logic             memwrite;
        logic             irwrite;
        logic             memtoreg;
        logic [SEL_W-1:0] regdst;
        logic             regwrite;
        logic             link;
        logic             alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic             zeroext;
        logic [SEL_W-1:0] pcsrc;
        logic [ALU_W-1:0] alucontrol;
        logic             illegal_op;
        logic             instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_funct_dec.sv
// R-type funct decoder: ALU operation plus a valid flag for trapping.
module mc_funct_dec
    import mips_mc_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALU_W-1:0]   alucontrol,
    output logic               valid
);

    // Unknown functs still drive add so the ALU select is never undefined.
    always_comb begin
        alucontrol = ALU_ADD;
        valid      = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a memory-ready handshake, optional memory timeout and illegal-op trap.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TRAP_HALT   = 1,
    parameter int unsigned HAS_JAL     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               invertzero,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic [SEL_W-1:0]   regdst,
    output logic               regwrite,
    output logic               link,
    output logic               alusrca,
    output logic [SEL_W-1:0]   alusrcb,
    output logic               zeroext,
    output logic [SEL_W-1:0]   pcsrc,
    output logic [ALU_W-1:0]   alucontrol,
    output logic               illegal_op,
    output logic               bus_error,
    output logic               instr_done
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state, state_next;
    ctrl_t            ctrl;
    logic             cls_ori, cls_bne, cls_sw;
    logic             trap_seen;
    logic             bus_err_q;
    logic [CNT_W-1:0] cnt;
    logic             mem_wait_c, timeout_c;
    logic [ALU_W-1:0] fn_alu;
    logic             fn_valid;

    mc_funct_dec u_funct_dec (
        .funct      (funct),
        .alucontrol (fn_alu),
        .valid      (fn_valid)
    );

    assign mem_wait_c = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
    assign timeout_c  = (MEM_TIMEOUT > 0) && mem_wait_c
                        && (32'(cnt) == MEM_TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            cls_ori   <= 1'b0;
            cls_bne   <= 1'b0;
            cls_sw    <= 1'b0;
            trap_seen <= 1'b0;
            bus_err_q <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            trap_seen <= (state == TRAP);
            if (timeout_c) bus_err_q <= 1'b1;
            // Wait counter only runs while a memory state is stalled in place.
            if (MEM_TIMEOUT > 0 && mem_wait_c && state_next == state) cnt <= cnt + CNT_W'(1);
            else                                                       cnt <= '0;
            if (state == DECODE) begin
                cls_ori <= (op == OP_ORI);
                cls_bne <= (op == OP_BNE);
                cls_sw  <= (op == OP_SW);
            end
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = '0;
        case (state)
            FETCH: begin
                ctrl.memread    = 1'b1;
                ctrl.alusrcb    = SRCB_FOUR;
                ctrl.alucontrol = ALU_ADD;
                if (mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                ctrl.alusrcb    = SRCB_IMM_SH;
                ctrl.alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:    state_next = MEMADR;
                    OP_RTYPE:        state_next = EXEC;
                    OP_ADDI, OP_ORI: state_next = IMMEX;
                    OP_BEQ, OP_BNE:  state_next = BRANCH;
                    OP_J:            state_next = JUMP;
                    OP_JAL:          state_next = (HAS_JAL != 0) ? JAL : TRAP;
                    default:         state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_IMM;
                ctrl.alucontrol = ALU_ADD;
                state_next      = cls_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regdst     = REGDST_RT;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_next      = FETCH;
                end
            end
            EXEC: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_B;
                ctrl.alucontrol = fn_alu;
                state_next      = fn_valid ? ALUWB : TRAP;
            end
            ALUWB: begin
                ctrl.regdst     = REGDST_RD;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            IMMEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_IMM;
                ctrl.alucontrol = cls_ori ? ALU_OR : ALU_ADD;
                ctrl.zeroext    = cls_ori;
                state_next      = IMMWB;
            end
            IMMWB: begin
                ctrl.regdst     = REGDST_RT;
                ctrl.regwrite   = 1'b1;
                ctrl.zeroext    = cls_ori;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_B;
                ctrl.alucontrol = ALU_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.invertzero = cls_bne;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            JAL: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.regdst     = REGDST_RA;
                ctrl.link       = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            TRAP: begin
                ctrl.illegal_op = !trap_seen;
                state_next      = (TRAP_HALT != 0) ? TRAP : FETCH;
            end
            ERR:     state_next = ERR;
            default: state_next = FETCH;
        endcase
        if (timeout_c) state_next = ERR;
    end

    assign pcwrite    = ctrl.pcwrite;
    assign branch     = ctrl.branch;
    assign invertzero = ctrl.invertzero;
    assign iord       = ctrl.iord;
    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign irwrite    = ctrl.irwrite;
    assign memtoreg   = ctrl.memtoreg;
    assign regdst     = ctrl.regdst;
    assign regwrite   = ctrl.regwrite;
    assign link       = ctrl.link;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign zeroext    = ctrl.zeroext;
    assign pcsrc      = ctrl.pcsrc;
    assign alucontrol = ctrl.alucontrol;
    assign illegal_op = ctrl.illegal_op;
    assign instr_done = ctrl.instr_done;
    assign bus_error  = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: default-parameter instance driven
// from a vector table, second instance (timeout, no JAL, non-halting trap) by hand.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       pcwrite, branch, invertzero, iord, memread, memwrite, irwrite, memtoreg;
        logic [1:0] regdst;
        logic       regwrite, link, alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op, bus_error, instr_done;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       rdy;
        ctl_t       exp;
    } vec_t;

    localparam ctl_t E_ZERO     = '0;
    localparam ctl_t E_FETCH_W  = '{memread:1'b1, alusrcb:2'b01, alucontrol:3'b010, default:'0};
    localparam ctl_t E_FETCH_GO = '{memread:1'b1, alusrcb:2'b01, alucontrol:3'b010,
                                    irwrite:1'b1, pcwrite:1'b1, default:'0};
    localparam ctl_t E_DECODE   = '{alusrcb:2'b11, alucontrol:3'b010, default:'0};
    localparam ctl_t E_MEMADR   = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b010, default:'0};
    localparam ctl_t E_MEMRD    = '{iord:1'b1, memread:1'b1, default:'0};
    localparam ctl_t E_MEMWB    = '{memtoreg:1'b1, regwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_MEMWR_W  = '{iord:1'b1, memwrite:1'b1, default:'0};
    localparam ctl_t E_MEMWR_GO = '{iord:1'b1, memwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_EXEC_ADD = '{alusrca:1'b1, alucontrol:3'b010, default:'0};
    localparam ctl_t E_ALUWB    = '{regdst:2'b01, regwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_IMMEX_AD = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b010, default:'0};
    localparam ctl_t E_IMMEX_OR = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b001,
                                    zeroext:1'b1, default:'0};
    localparam ctl_t E_IMMWB_AD = '{regwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_IMMWB_OR = '{regwrite:1'b1, instr_done:1'b1, zeroext:1'b1, default:'0};
    localparam ctl_t E_BEQ      = '{alusrca:1'b1, alucontrol:3'b110, branch:1'b1, pcsrc:2'b01,
                                    instr_done:1'b1, default:'0};
    localparam ctl_t E_BNE      = '{alusrca:1'b1, alucontrol:3'b110, branch:1'b1, pcsrc:2'b01,
                                    invertzero:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_JUMP     = '{pcsrc:2'b10, pcwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_JAL      = '{pcsrc:2'b10, pcwrite:1'b1, regdst:2'b10, link:1'b1,
                                    regwrite:1'b1, instr_done:1'b1, default:'0};
    localparam ctl_t E_TRAP_IN  = '{illegal_op:1'b1, default:'0};
    localparam ctl_t E_ERR      = '{bus_error:1'b1, default:'0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, rdy_a, rstn_b, rdy_b;
    logic [5:0] op_a, funct_a, op_b, funct_b;

    logic pcwrite_a, branch_a, invertzero_a, iord_a, memread_a, memwrite_a, irwrite_a, memtoreg_a;
    logic regwrite_a, link_a, alusrca_a, zeroext_a, illegal_op_a, bus_error_a, instr_done_a;
    logic [1:0] regdst_a, alusrcb_a, pcsrc_a;
    logic [2:0] alucontrol_a;
    logic pcwrite_b, branch_b, invertzero_b, iord_b, memread_b, memwrite_b, irwrite_b, memtoreg_b;
    logic regwrite_b, link_b, alusrca_b, zeroext_b, illegal_op_b, bus_error_b, instr_done_b;
    logic [1:0] regdst_b, alusrcb_b, pcsrc_b;
    logic [2:0] alucontrol_b;

    ctl_t act_a, act_b;
    assign act_a = {pcwrite_a, branch_a, invertzero_a, iord_a, memread_a, memwrite_a, irwrite_a,
                    memtoreg_a, regdst_a, regwrite_a, link_a, alusrca_a, alusrcb_a, zeroext_a,
                    pcsrc_a, alucontrol_a, illegal_op_a, bus_error_a, instr_done_a};
    assign act_b = {pcwrite_b, branch_b, invertzero_b, iord_b, memread_b, memwrite_b, irwrite_b,
                    memtoreg_b, regdst_b, regwrite_b, link_b, alusrca_b, alusrcb_b, zeroext_b,
                    pcsrc_b, alucontrol_b, illegal_op_b, bus_error_b, instr_done_b};

    mips_multicycle_control dut_a (
        .clk(clk), .rst_n(rstn_a), .op(op_a), .funct(funct_a), .mem_ready(rdy_a),
        .pcwrite(pcwrite_a), .branch(branch_a), .invertzero(invertzero_a), .iord(iord_a),
        .memread(memread_a), .memwrite(memwrite_a), .irwrite(irwrite_a), .memtoreg(memtoreg_a),
        .regdst(regdst_a), .regwrite(regwrite_a), .link(link_a), .alusrca(alusrca_a),
        .alusrcb(alusrcb_a), .zeroext(zeroext_a), .pcsrc(pcsrc_a), .alucontrol(alucontrol_a),
        .illegal_op(illegal_op_a), .bus_error(bus_error_a), .instr_done(instr_done_a)
    );

    mips_multicycle_control #(.MEM_TIMEOUT(4), .TRAP_HALT(0), .HAS_JAL(0)) dut_b (
        .clk(clk), .rst_n(rstn_b), .op(op_b), .funct(funct_b), .mem_ready(rdy_b),
        .pcwrite(pcwrite_b), .branch(branch_b), .invertzero(invertzero_b), .iord(iord_b),
        .memread(memread_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .memtoreg(memtoreg_b),
        .regdst(regdst_b), .regwrite(regwrite_b), .link(link_b), .alusrca(alusrca_b),
        .alusrcb(alusrcb_b), .zeroext(zeroext_b), .pcsrc(pcsrc_b), .alucontrol(alucontrol_b),
        .illegal_op(illegal_op_b), .bus_error(bus_error_b), .instr_done(instr_done_b)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    task automatic check(input string nm, input ctl_t act, input ctl_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                                input ctl_t exp);
        vec_t v;
        v.op = op; v.funct = fn; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // One clock of dut_b: drive, check at negedge, advance past the next edge.
    task automatic step_b(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic rdy, input ctl_t exp);
        op_b = op; funct_b = fn; rdy_b = rdy;
        @(negedge clk);
        check(nm, act_b, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alus [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        ctl_t ex;

        rstn_a = 1'b0; rdy_a = 1'b0; op_a = '0; funct_a = '0;
        rstn_b = 1'b0; rdy_b = 1'b0; op_b = '0; funct_b = '0;

        // Vector table for dut_a, one row per clock.
        add(6'h00, 6'h20, 1'b0, E_FETCH_W);
        for (int i = 0; i < 5; i++) begin
            ex = E_EXEC_ADD;
            ex.alucontrol = alus[i];
            add(6'h00, fns[i], 1'b1, E_FETCH_GO);
            add(6'h00, fns[i], 1'b1, E_DECODE);
            add(6'h00, fns[i], 1'b1, ex);
            add(6'h00, fns[i], 1'b1, E_ALUWB);
        end
        add(6'b100011, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b100011, 6'h00, 1'b1, E_DECODE);
        add(6'b100011, 6'h00, 1'b1, E_MEMADR);
        add(6'b100011, 6'h00, 1'b0, E_MEMRD);
        add(6'b100011, 6'h00, 1'b0, E_MEMRD);
        add(6'b100011, 6'h00, 1'b0, E_MEMRD);
        add(6'b100011, 6'h00, 1'b1, E_MEMRD);
        add(6'b100011, 6'h00, 1'b1, E_MEMWB);
        add(6'b101011, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b101011, 6'h00, 1'b1, E_DECODE);
        add(6'b101011, 6'h00, 1'b1, E_MEMADR);
        add(6'b101011, 6'h00, 1'b0, E_MEMWR_W);
        add(6'b101011, 6'h00, 1'b1, E_MEMWR_GO);
        add(6'b001101, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b001101, 6'h00, 1'b1, E_DECODE);
        add(6'b001101, 6'h00, 1'b1, E_IMMEX_OR);
        add(6'b001101, 6'h00, 1'b1, E_IMMWB_OR);
        add(6'b001000, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b001000, 6'h00, 1'b1, E_DECODE);
        add(6'b001000, 6'h00, 1'b1, E_IMMEX_AD);
        add(6'b001000, 6'h00, 1'b1, E_IMMWB_AD);
        add(6'b000101, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b000101, 6'h00, 1'b1, E_DECODE);
        add(6'b000101, 6'h00, 1'b1, E_BNE);
        add(6'b000100, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b000100, 6'h00, 1'b1, E_DECODE);
        add(6'b000100, 6'h00, 1'b1, E_BEQ);
        add(6'b000010, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b000010, 6'h00, 1'b1, E_DECODE);
        add(6'b000010, 6'h00, 1'b1, E_JUMP);
        add(6'b000011, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b000011, 6'h00, 1'b1, E_DECODE);
        add(6'b000011, 6'h00, 1'b1, E_JAL);
        add(6'b000011, 6'h00, 1'b0, E_FETCH_W);
        add(6'b000011, 6'h00, 1'b1, E_FETCH_GO);
        add(6'b111111, 6'h00, 1'b1, E_DECODE);
        add(6'b111111, 6'h00, 1'b1, E_TRAP_IN);
        add(6'b000000, 6'h20, 1'b1, E_ZERO);
        add(6'b000000, 6'h20, 1'b1, E_ZERO);

        // dut_a: reset state, then the table.
        repeat (2) @(posedge clk);
        #1;
        check("a_reset", act_a, E_FETCH_W);
        rstn_a = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            op_a = vecs[i].op; funct_a = vecs[i].funct; rdy_a = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("a_vec%0d_op%b", i, vecs[i].op), act_a, vecs[i].exp);
            @(posedge clk); #1;
        end
        // Async reset out of the halting trap.
        rdy_a = 1'b0; rstn_a = 1'b0;
        #2;
        check("a_trap_reset", act_a, E_FETCH_W);
        rstn_a = 1'b1;

        // dut_b: ready arriving on the limit cycle wins over the timeout.
        @(negedge clk);
        check("b_reset", act_b, E_FETCH_W);
        @(posedge clk); #1;
        rstn_b = 1'b1;
        step_b("b_wait0", 6'b000010, 6'h00, 1'b0, E_FETCH_W);
        step_b("b_wait1", 6'b000010, 6'h00, 1'b0, E_FETCH_W);
        step_b("b_wait2", 6'b000010, 6'h00, 1'b0, E_FETCH_W);
        step_b("b_limit_rdy", 6'b000010, 6'h00, 1'b1, E_FETCH_GO);
        step_b("b_j_decode", 6'b000010, 6'h00, 1'b1, E_DECODE);
        step_b("b_j_jump", 6'b000010, 6'h00, 1'b1, E_JUMP);
        // JAL without HAS_JAL traps, then refetches.
        step_b("b_jal_fetch", 6'b000011, 6'h00, 1'b1, E_FETCH_GO);
        step_b("b_jal_decode", 6'b000011, 6'h00, 1'b1, E_DECODE);
        step_b("b_jal_trap", 6'b000011, 6'h00, 1'b1, E_TRAP_IN);
        step_b("b_jal_refetch", 6'b000000, 6'h3f, 1'b1, E_FETCH_GO);
        // Unknown funct traps without a register write.
        step_b("b_fn_decode", 6'b000000, 6'h3f, 1'b1, E_DECODE);
        step_b("b_fn_exec", 6'b000000, 6'h3f, 1'b1, E_EXEC_ADD);
        step_b("b_fn_trap", 6'b000000, 6'h3f, 1'b1, E_TRAP_IN);
        // Stuck fetch: four wait cycles then ERR with sticky bus_error.
        step_b("b_to0", 6'b000000, 6'h20, 1'b0, E_FETCH_W);
        step_b("b_to1", 6'b000000, 6'h20, 1'b0, E_FETCH_W);
        step_b("b_to2", 6'b000000, 6'h20, 1'b0, E_FETCH_W);
        step_b("b_to3", 6'b000000, 6'h20, 1'b0, E_FETCH_W);
        step_b("b_err0", 6'b000000, 6'h20, 1'b0, E_ERR);
        step_b("b_err_rdy", 6'b000000, 6'h20, 1'b1, E_ERR);
        step_b("b_err_hold", 6'b000000, 6'h20, 1'b1, E_ERR);
        rdy_b = 1'b0; rstn_b = 1'b0;
        #2;
        check("b_err_reset", act_b, E_FETCH_W);
        @(posedge clk); #1;
        rstn_b = 1'b1;
        step_b("b_post_reset", 6'b000000, 6'h20, 1'b1, E_FETCH_GO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
